mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mul_seq.sv | 117 +++++++++++
 tb/tb_mul_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// mul_seq: sequential radix-2 shift-add multiplier with DONE pulse and NZ flags.
// Long/signed products (and the FIX negation state) exist only when MUL_SEQ_LONG_MUL_EN is defined.
module mul_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Start,
  input  logic         Flush,
  input  logic         Long,
  input  logic         Signed,
  input  logic [W-1:0] SrcA,
  input  logic [W-1:0] SrcB,
  output logic         Busy,
  output logic         Stall,
  output logic         Done,
  output logic [W-1:0] ResultLo,
  output logic [W-1:0] ResultHi,
  output logic [1:0]   NZ
);
  localparam int CW = $clog2(W) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic accept, sgn, long_q, neg_q;
  logic [W-1:0] a_in;
`ifdef MUL_SEQ_LONG_MUL_EN
  localparam int AW = 2 * W;
  logic long_d, neg_d;
  assign sgn = Long & Signed;
  assign long_d = accept ? Long : long_q;
  assign neg_d = accept ? sgn & (SrcA[W-1] ^ SrcB[W-1]) : neg_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      long_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      long_q <= long_d;
      neg_q <= neg_d;
    end
  end
`else
  localparam int AW = W;
  logic unused_cfg;
  assign {sgn, long_q, neg_q} = '0;
  assign unused_cfg = Long ^ Signed;
`endif
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [W-1:0] mplier_q, mplier_d, lo_q, lo_d, hi_q, hi_d;
  logic [1:0] nz_q, nz_d;
  logic [2*W-1:0] prod;
  logic to_done;
  assign accept = (state_q == IDLE) & Start & ~Flush;
  // signed long operands are held as magnitudes; the sign is reapplied in FIX
  assign a_in = (sgn & SrcA[W-1]) ? -SrcA : SrcA;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      IDLE: if (Start) begin
        state_d = CALC;
        cnt_d = CW'(W);
        acc_d = '0;
        mcand_d = AW'(a_in);
        mplier_d = (sgn & SrcB[W-1]) ? -SrcB : SrcB;
      end
      CALC: begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? (neg_q ? FIX : DONE) : CALC;
      end
      FIX: begin
        acc_d = -acc_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (Flush) state_d = IDLE;
  end
  assign prod = (2*W)'(acc_d);
  assign to_done = (state_d == DONE);
  assign lo_d = to_done ? prod[W-1:0] : lo_q;
  assign hi_d = to_done ? (long_q ? prod[2*W-1:W] : '0) : hi_q;
  assign nz_d = to_done ? {long_q ? prod[2*W-1] : prod[W-1], long_q ? prod == '0 : prod[W-1:0] == '0} : nz_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      lo_q <= '0;
      hi_q <= '0;
      nz_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      nz_q <= nz_d;
    end
  end
  assign Busy = (state_q != IDLE);
  assign Stall = (state_q == CALC) | (state_q == FIX);
  assign Done = (state_q == DONE);
  assign ResultLo = lo_q;
  assign ResultHi = hi_q;
  assign NZ = nz_q;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: random and directed checks of mul_seq against a latency/product model.
module tb_mul_seq;
  localparam int W = 32;
`ifdef MUL_SEQ_LONG_MUL_EN
  localparam bit LM = 1'b1;
`else
  localparam bit LM = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, Start = 1'b0, Flush = 1'b0, Long = 1'b0, Signed = 1'b0;
  logic [W-1:0] SrcA = '0, SrcB = '0;
  logic Busy, Stall, Done;
  logic [W-1:0] ResultLo, ResultHi;
  logic [1:0] NZ;
  int checks = 0, errors = 0;

  mul_seq #(.W(W)) dut (
    .clk(clk), .reset(rst), .Start(Start), .Flush(Flush), .Long(Long), .Signed(Signed),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Stall(Stall), .Done(Done),
    .ResultLo(ResultLo), .ResultHi(ResultHi), .NZ(NZ)
  );

  always #5 clk = ~clk;

  // product, flags and total busy cycles straight from the arithmetic definition
  function automatic void model(input logic [31:0] a, b, input logic l, s,
                                output logic [31:0] lo, hi, output logic [1:0] nz, output int lat);
    logic [63:0] p;
    logic lg, sg;
    longint sa, sb;
    lg = LM & l;
    sg = LM & l & s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = sg ? 64'(sa * sb) : 64'(a) * 64'(b);
    lo = p[31:0];
    hi = lg ? p[63:32] : 32'd0;
    nz = {lg ? p[63] : p[31], lg ? (p == 64'd0) : (p[31:0] == 32'd0)};
    lat = W + 1 + ((sg && (a[31] ^ b[31])) ? 1 : 0);
  endfunction

  int m_cnt = 0, p_lat;
  logic [31:0] m_lo = '0, m_hi = '0, p_lo, p_hi;
  logic [1:0] m_nz = '0, p_nz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0;
      m_lo = '0;
      m_hi = '0;
      m_nz = '0;
    end else if (Flush) m_cnt = 0;
    else if (m_cnt == 0) begin
      if (Start) begin
        model(SrcA, SrcB, Long, Signed, p_lo, p_hi, p_nz, p_lat);
        m_cnt = p_lat;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) begin
        m_lo = p_lo;
        m_hi = p_hi;
        m_nz = p_nz;
      end
    end
  end

  always @(negedge clk) begin
    logic [68:0] act, exp;
    act = {Busy, Stall, Done, NZ, ResultHi, ResultLo};
    exp = {m_cnt != 0, m_cnt > 1, m_cnt == 1, m_nz, m_hi, m_lo};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got %h exp %h", $time, act, exp);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, b, input logic l, s, input int p1, p2, fc, rc,
                        output int dc, dn, output logic busy34);
    @(posedge clk); #2;
    SrcA = a; SrcB = b; Long = l; Signed = s; Start = 1'b1;
    @(posedge clk); #2;
    Start = 1'b0;
    SrcA = $urandom; SrcB = $urandom; Long = 1'($urandom); Signed = 1'($urandom);
    dc = 0; dn = 0; busy34 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (Done) begin
        dn++;
        if (dc == 0) dc = c;
      end
      if (c == 34) busy34 = Busy;
      Start = (c == p1) || (c == p2);
      Flush = (c == fc);
      rst = (c == rc);
      @(posedge clk); #2;
    end
    Start = 1'b0; Flush = 1'b0; rst = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dc, dn;
    logic b34;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_state", 64'({Busy, Stall, Done, NZ, ResultHi[0], ResultLo}), 64'd0);
    rst = 1'b0;

    run_op(32'd7, 32'd6, 1'b0, 1'b0, 0, 0, 0, 0, dc, dn, b34);
    chk("mul7x6_lat", 64'(dc), 64'd33);
    chk("mul7x6_res", {ResultHi, ResultLo}, 64'd42);
    chk("mul7x6_nz", 64'(NZ), 64'd0);

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0, 0, 0, dc, dn, b34);
    chk("umull_lat", 64'(dc), 64'd33);
    chk("umull_res", {ResultHi, ResultLo}, LM ? 64'hFFFF_FFFE_0000_0001 : 64'h0000_0000_0000_0001);
    chk("umull_nz", 64'(NZ), LM ? 64'd2 : 64'd0);

    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1, 0, 0, 0, 0, dc, dn, b34);
    chk("smull_lat", 64'(dc), LM ? 64'd34 : 64'd33);
    chk("smull_res", {ResultHi, ResultLo}, LM ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0000_FFFF_FFF1);
    chk("smull_nz", 64'(NZ), 64'd2);

    run_op(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1, 0, 0, 0, 0, dc, dn, b34);
    chk("m1x2_lat", 64'(dc), LM ? 64'd34 : 64'd33);
    chk("m1x2_res", {ResultHi, ResultLo}, LM ? 64'hFFFF_FFFF_FFFF_FFFE : 64'h0000_0000_FFFF_FFFE);

    run_op(32'd0, 32'd5, 1'b0, 1'b0, 0, 0, 0, 0, dc, dn, b34);
    chk("zero_nz", 64'(NZ), 64'd1);
    chk("zero_res", {ResultHi, ResultLo}, 64'd0);

    run_op(32'd7, 32'd6, 1'b0, 1'b0, 5, 33, 0, 0, dc, dn, b34);
    chk("busy_start_dn", 64'(dn), 64'd1);
    chk("busy_start_lat", 64'(dc), 64'd33);
    chk("busy_start_b34", 64'(b34), 64'd0);
    chk("busy_start_res", 64'(ResultLo), 64'd42);

    run_op(32'd3, 32'd3, 1'b0, 1'b0, 0, 0, 10, 0, dc, dn, b34);
    chk("flush_dn", 64'(dn), 64'd0);
    chk("flush_keep", {ResultHi, ResultLo}, 64'd42);

    run_op(32'd3, 32'd3, 1'b0, 1'b0, 0, 0, 0, 10, dc, dn, b34);
    chk("reset_dn", 64'(dn), 64'd0);
    chk("reset_clr", 64'({NZ, ResultHi[0], ResultLo}), 64'd0);

    for (int i = 0; i < 60; i++) begin
      int fc;
      fc = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 34) : 0;
      run_op(pick(), pick(), 1'($urandom), 1'($urandom), $urandom_range(1, 33), 0, fc, 0, dc, dn, b34);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
